// File: rtl/hamming_serial_rx.sv
// Bit-serial SECDED Hamming (12,7) receiver: deserialises a code word,
// corrects single errors, presents the word on valid/ready and keeps error counters.
module hamming_serial_rx #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdi,
  input  logic             sdi_valid,
  input  logic             sof,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [6:0]       data_out,
  output logic [1:0]       ds,
  output logic [3:0]       syndrome,
  output logic             out_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] det_cnt
);

  localparam logic [3:0]       IDLE    = 4'd0;
  localparam logic [3:0]       LAST    = 4'd11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Handshake: a word transfers on any edge where out_valid && out_ready;
  // while out_valid && !out_ready the word and its status stay frozen.

  // bit_cnt is the framing state: 0 = IDLE, k = RX(k), next index to store.
  logic [3:0]  bit_cnt;
  logic [3:0]  cnt_n;
  logic [10:0] rx_bits;

  logic        abort;
  logic        word_done;
  logic        store_bit;
  logic [3:0]  wr_idx;

  logic [11:0] code;
  logic        par;
  logic [3:0]  chk;
  logic [10:0] fixed;
  logic [1:0]  ds_n;
  logic [6:0]  data_n;

  logic        load;
  logic        drop;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bit_cnt <= IDLE;
    else      bit_cnt <= cnt_n;
  end

  // Next-state
  always_comb begin
    cnt_n = bit_cnt;
    if (sdi_valid) begin
      if (sof)                   cnt_n = 4'd1;
      else if (bit_cnt == LAST)  cnt_n = IDLE;
      else if (bit_cnt != IDLE)  cnt_n = bit_cnt + 4'd1;
    end
  end

  // State-derived controls
  always_comb begin
    abort     = sdi_valid && sof && (bit_cnt != IDLE);
    word_done = sdi_valid && !sof && (bit_cnt == LAST);
    store_bit = sdi_valid && (sof || ((bit_cnt != IDLE) && (bit_cnt != LAST)));
    wr_idx    = sof ? 4'd0 : bit_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           rx_bits         <= '0;
    else if (store_bit) rx_bits[wr_idx] <= sdi;
  end

  // Decode sees the 11 stored bits plus the index-11 bit still on sdi.
  always_comb begin
    code   = {sdi, rx_bits};
    par    = ^code;
    chk[0] = code[0] ^ code[2] ^ code[4] ^ code[6] ^ code[8] ^ code[10];
    chk[1] = code[1] ^ code[2] ^ code[5] ^ code[6] ^ code[9] ^ code[10];
    chk[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
    chk[3] = code[7] ^ code[8] ^ code[9] ^ code[10];
    fixed  = code[10:0];
    for (int i = 0; i < 11; i++) begin
      if (par && (chk == 4'(i + 1))) fixed[i] = ~code[i];
    end
    if (!par && (chk == 4'd0))     ds_n = 2'b00;
    else if (par && (chk <= LAST)) ds_n = 2'b01;
    else                           ds_n = 2'b10;
    data_n = {fixed[10], fixed[9], fixed[8], fixed[6], fixed[5], fixed[4], fixed[2]};
  end

  always_comb begin
    load = word_done && (!out_valid || out_ready);
    drop = word_done && out_valid && !out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out  <= '0;
      ds        <= '0;
      syndrome  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= abort;
      if (load) begin
        data_out  <= data_n;
        ds        <= ds_n;
        syndrome  <= chk;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Clear wins over a same-edge increment or overrun set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corr_cnt <= '0;
      det_cnt  <= '0;
      overrun  <= 1'b0;
    end else if (clr_cnt) begin
      corr_cnt <= '0;
      det_cnt  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (drop) overrun <= 1'b1;
      if (load && (ds_n == 2'b01) && (corr_cnt != CNT_MAX)) corr_cnt <= corr_cnt + CNT_W'(1);
      if (load && (ds_n == 2'b10) && (det_cnt != CNT_MAX))  det_cnt  <= det_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Directed bench for hamming_serial_rx: clean/single/double words, overrun,
// framing aborts with gaps, counter saturation (CNT_W=2) and mid-frame reset.
module tb_hamming_serial_rx;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             sdi;
  logic             sdi_valid;
  logic             sof;
  logic             out_ready;
  logic             clr_cnt;
  logic [6:0]       data_out;
  logic [1:0]       ds;
  logic [3:0]       syndrome;
  logic             out_valid;
  logic             frame_err;
  logic             overrun;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] det_cnt;

  int n_chk;
  int n_fail;
  int fe_cnt;
  int word_cnt;

  // Code words, bit i = code index i (sent first).
  localparam logic [11:0] CW_CLEAN = 12'b010011100101;
  localparam logic [11:0] CW_E5    = 12'b010011000101;
  localparam logic [11:0] CW_E2_9  = 12'b011011100001;
  localparam logic [11:0] CW_E11   = 12'b110011100101;
  localparam logic [11:0] CW_E037  = 12'b010001101100;
  localparam logic [6:0]  D_CLEAN  = 7'h4D;
  localparam logic [6:0]  D_E2_9   = 7'h6C;

  hamming_serial_rx #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sdi       (sdi),
    .sdi_valid (sdi_valid),
    .sof       (sof),
    .out_ready (out_ready),
    .clr_cnt   (clr_cnt),
    .data_out  (data_out),
    .ds        (ds),
    .syndrome  (syndrome),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .corr_cnt  (corr_cnt),
    .det_cnt   (det_cnt)
  );

  // Clock / monitors
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (out_valid && out_ready) word_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers: each bit is presented from one negedge to the next.
  task automatic send_bits(input logic [11:0] cw, input int first, input int last,
                           input bit use_sof, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          sdi       = 1'($urandom_range(0, 1));
          sdi_valid = 1'b0;
          sof       = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      sdi       = cw[i];
      sdi_valid = 1'b1;
      sof       = use_sof && (i == first);
    end
  endtask

  task automatic send_frame(input logic [11:0] cw, input bit gaps);
    send_bits(cw, 0, 11, 1'b1, gaps);
    @(negedge clk);
    sdi_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [6:0] d, input logic [1:0] s,
                          input logic [3:0] syn);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(data_out),  32'(d));
    chk({tag, ".ds"},    32'(ds),        32'(s));
    chk({tag, ".syn"},   32'(syndrome),  32'(syn));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".data"},  32'(data_out),  32'd0);
    chk({tag, ".ds"},    32'(ds),        32'd0);
    chk({tag, ".syn"},   32'(syndrome),  32'd0);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".ferr"},  32'(frame_err), 32'd0);
    chk({tag, ".ovr"},   32'(overrun),   32'd0);
    chk({tag, ".corr"},  32'(corr_cnt),  32'd0);
    chk({tag, ".det"},   32'(det_cnt),   32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; fe_cnt = 0; word_cnt = 0;
    rst = 1'b0; sdi = 1'b0; sdi_valid = 1'b0; sof = 1'b0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Clean word, then single, double, index-11 and check>=12 cases.
    send_frame(CW_CLEAN, 1'b0);
    chk_word("clean", D_CLEAN, 2'b00, 4'd0);
    chk("clean.corr", 32'(corr_cnt), 32'd0);
    chk("clean.det",  32'(det_cnt),  32'd0);

    send_frame(CW_E5, 1'b0);
    chk_word("e5", D_CLEAN, 2'b01, 4'd6);
    chk("e5.corr", 32'(corr_cnt), 32'd1);

    send_frame(CW_E2_9, 1'b0);
    chk_word("e2_9", D_E2_9, 2'b10, 4'd9);
    chk("e2_9.det", 32'(det_cnt), 32'd1);

    send_frame(CW_E11, 1'b0);
    chk_word("e11", D_CLEAN, 2'b01, 4'd0);
    chk("e11.corr", 32'(corr_cnt), 32'd2);

    send_frame(CW_E037, 1'b0);
    chk_word("e037", D_CLEAN, 2'b10, 4'd13);
    chk("e037.det",  32'(det_cnt),  32'd2);
    chk("e037.corr", 32'(corr_cnt), 32'd2);

    // Overrun: second frame lands while the first is still held.
    pulse_clr();
    chk("clr1.corr", 32'(corr_cnt), 32'd0);
    chk("clr1.det",  32'(det_cnt),  32'd0);
    out_ready = 1'b0;
    send_frame(CW_E5, 1'b0);
    chk("ovr.pre", 32'(overrun), 32'd0);
    send_frame(CW_E2_9, 1'b0);
    chk_word("ovr.held", D_CLEAN, 2'b01, 4'd6);
    chk("ovr.flag", 32'(overrun),  32'd1);
    chk("ovr.corr", 32'(corr_cnt), 32'd1);
    chk("ovr.det",  32'(det_cnt),  32'd0);
    pulse_clr();
    chk("clr2.ovr",   32'(overrun),   32'd0);
    chk("clr2.corr",  32'(corr_cnt),  32'd0);
    chk("clr2.det",   32'(det_cnt),   32'd0);
    chk("clr2.valid", 32'(out_valid), 32'd1);
    chk("clr2.data",  32'(data_out),  32'(D_CLEAN));
    out_ready = 1'b1;
    @(negedge clk);
    chk("accept.valid", 32'(out_valid), 32'd0);

    // Framing abort after 5 bits, with random gaps.
    fe_cnt = 0; word_cnt = 0;
    send_bits(CW_E2_9, 0, 4, 1'b1, 1'b1);
    send_frame(CW_CLEAN, 1'b1);
    chk_word("frm", D_CLEAN, 2'b00, 4'd0);
    @(negedge clk);
    chk("frm.fe_cnt",   32'(fe_cnt),   32'd1);
    chk("frm.word_cnt", 32'(word_cnt), 32'd1);

    // Saturation at 2^CNT_W-1.
    for (int i = 0; i < 5; i++) send_frame(CW_E5, 1'b0);
    chk("sat.corr", 32'(corr_cnt), 32'd3);
    chk("sat.det",  32'(det_cnt),  32'd0);

    // Reset mid-frame, then the tail without sof must be ignored.
    send_bits(CW_CLEAN, 0, 5, 1'b1, 1'b0);
    @(negedge clk);
    sdi_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    word_cnt = 0;
    send_bits(CW_CLEAN, 6, 11, 1'b0, 1'b0);
    @(negedge clk);
    sdi_valid = 1'b0;
    @(negedge clk);
    chk("tail.valid", 32'(out_valid), 32'd0);
    chk("tail.words", 32'(word_cnt),  32'd0);
    send_frame(CW_E5, 1'b0);
    chk_word("post", D_CLEAN, 2'b01, 4'd6);
    chk("post.corr", 32'(corr_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_serial_rx.md
Name: hamming_serial_rx

Overview:
- Bit-serial receiver for the 12-bit SECDED Hamming code word (7 data bits, parity at indices 0/1/3/7, overall parity at index 11).
- Deserialises a code word, decodes it and corrects single errors in one registered stage.
- Presents the result on a valid/ready output and keeps saturating error-statistics counters.
- Sits at the far end of the serial link driven by the encoder path. It is the receive/decode side of that link.

Parameters:
CNT_W, 8, width of the corrected and detected error counters (saturating).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
sdi  input  1  serial code word bit, index 0 first, index 11 last
sdi_valid  input  1  sdi is sampled only when high
sof  input  1  start of frame, qualified by sdi_valid, marks the bit as index 0
out_ready  input  1  consumer accepts the output word
clr_cnt  input  1  synchronous clear of counters and overrun
data_out  output  7  corrected data, [0:6] = code indices 2,4,5,6,8,9,10
ds  output  2  00 = clean, 01 = single error corrected, 10 = double/uncorrectable
syndrome  output  4  check value of the decoded word, 0 when clean or when only index 11 flipped
out_valid  output  1  output word valid
frame_err  output  1  one-cycle pulse when sof aborts a partial frame
overrun  output  1  sticky; a completed frame was dropped
corr_cnt  output  CNT_W  count of ds=01 words
det_cnt  output  CNT_W  count of ds=10 words

Behaviour:
- Reset (rst low, asynchronous):
  - bit counter = 0; receiver is idle, awaiting sof.
  - All outputs are 0, including out_valid, ds, syndrome, data_out, counters, overrun and frame_err.
- Framing:
  - Counter states are IDLE, then RX(k) for k = 1..11.
  - In IDLE, a bit is accepted only when sdi_valid && sof. That bit is stored as index 0 and the counter goes to 1.
  - In RX(k), each sdi_valid bit is stored at index k and the counter increments.
  - sdi_valid low holds all state, so gaps between bits are allowed.
  - sof with sdi_valid in RX(k), k ≥ 1: the partial frame is discarded, frame_err pulses 1 cycle, and the bit is taken as index 0 of a new frame (counter = 1).
  - sof on the 12th bit (RX(11)) counts as an abort, not completion.
- Decode: combinational on the 11 stored bits plus the incoming index-11 bit.
  - p = XOR of all 12 bits.
  - check[0] = XOR of indices 0,2,4,6,8,10.
  - check[1] = XOR of indices 1,2,5,6,9,10.
  - check[2] = XOR of indices 3,4,5,6.
  - check[3] = XOR of indices 7,8,9,10.
  - p=0, check=0: ds=00.
  - p=1, check in 1..11: flip index check-1, ds=01.
  - p=1, check=0: index 11 is in error, data unaffected, ds=01, syndrome=0.
  - p=1, check in 12..15: ds=10, no correction.
  - p=0, check≠0: ds=10; data_out = uncorrected extracted bits.
- Latency: data_out/ds/syndrome are registered on the same edge that samples the 12th bit. out_valid is high in the following cycle.
- Output handshake:
  - The word holds stable while out_valid && !out_ready.
  - out_valid drops after the out_valid && out_ready edge, unless a new frame completes on that same edge. In that case the new word loads and out_valid stays 1 (back-to-back frames allowed).
- Overrun: if a frame completes while out_valid && !out_ready, the new word is dropped, the held word is kept, overrun is set sticky, and counters are not updated for the dropped word.
- Counters:
  - Counters update on the edge that loads the output word.
  - corr_cnt +1 for ds=01; det_cnt +1 for ds=10.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - clr_cnt zeroes corr_cnt, det_cnt and overrun, with priority over increment on the same edge; the increment is lost.
  - clr_cnt does not affect framing or the output word.
- Reset mid-frame discards everything; sof is required after reset is released.

Test Plan:
- Clean word: data 1011001 → code "101001110010" (index 0..11) serially, out_ready=1 → one cycle after the 12th bit: data_out=1011001, ds=00, syndrome=0, counters unchanged.
- Single error: same code with index 5 flipped ("101000110010") → data_out=1011001, ds=01, syndrome=6, corr_cnt=1.
- Double error: indices 2 and 9 flipped ("100001110110") → ds=10, syndrome=9, det_cnt=1; index-11-only flip ("101001110011") → ds=01, syndrome=0, data_out=1011001.
- Handshake/overrun: out_ready=0, send two complete frames → first word held, out_valid=1, overrun=1, counters reflect the first word only. Then clr_cnt=1 → overrun=0, corr_cnt=det_cnt=0.
- Framing: sof after 5 bits, random sdi_valid gaps, then a full clean frame → frame_err pulses once, only the clean frame is output, with correct data.
- Saturation/reset: CNT_W=2, send 5 single-error frames → corr_cnt=3. Assert rst mid-frame → all outputs 0 immediately, and the next frame decodes correctly only after sof.
